// File: rtl/bsg_test_rom_seq_pkg.sv
// Shared opcode/state encodings and the ROM-word layout for the test ROM sequencer.
// The word struct is a macro so each user can size the payload to its own parameter.
`ifndef BSG_TEST_ROM_SEQ_PKG_SV
`define BSG_TEST_ROM_SEQ_PKG_SV

`define BSG_TEST_ROM_SEQ_WORD_S(payload_width) \
  struct packed { \
    logic [bsg_test_rom_seq_pkg::opcode_width_lp-1:0] opcode; \
    logic [(payload_width)-1:0] payload; \
  }

package bsg_test_rom_seq_pkg;

  localparam int opcode_width_lp = 4;

  typedef enum logic [opcode_width_lp-1:0] {
    e_nop    = 4'd0,
    e_send   = 4'd1,
    e_wait   = 4'd2,
    e_finish = 4'd3,
    e_goto   = 4'd4
  } opcode_e;

  typedef enum logic [1:0] {
    eIdle = 2'd0,
    eRun  = 2'd1,
    eWait = 2'd2,
    eDone = 2'd3
  } state_e;

endpackage

`endif

// File: rtl/bsg_test_rom_seq_wait_ctr.sv
// Loadable down-counter for timed waits; saturates at zero and flags it.
module bsg_test_rom_seq_wait_ctr #(
  parameter int width_p = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [width_p-1:0] load_value,
  output logic               zero
);

  logic [width_p-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - width_p'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bsg_nonsynth_test_rom_sequencer.sv
// Walks an async-read test ROM, executing {opcode, payload} words and replaying SENDs onto a valid/ready stream.
// Define BSG_NONSYNTH_TEST_ROM_SEQUENCER_TRACE_EN to print an execution trace.
//
// state | meaning
// eIdle | out of reset, waiting for en_i; pc held at 0
// eRun  | executing the word at pc
// eWait | WAIT counter running down; no execution
// eDone | FINISH executed; terminal until reset_i
module bsg_nonsynth_test_rom_sequencer
  import bsg_test_rom_seq_pkg::*;
#(
  parameter int rom_addr_width_p = 8,
  parameter int payload_width_p  = 16,
  parameter int wait_ctr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [payload_width_p+3:0]  rom_data_i,
  output logic                        v_o,
  output logic [payload_width_p-1:0]  data_o,
  input  logic                        ready_i,
  output logic                        done_o,
  output logic                        error_o
);

  typedef `BSG_TEST_ROM_SEQ_WORD_S(payload_width_p) word_s;

  word_s                        word;
  state_e                       state, state_n;
  logic [rom_addr_width_p-1:0]  pc, pc_n;
  logic                         pending, pending_n;
  logic                         error, error_n;
  logic                         advance;
  logic                         load;
  logic                         ctr_zero;
  logic                         send_v;
  logic [wait_ctr_width_p-1:0]  wait_cycles;
  logic                         unused_payload_bits;

  assign word                = rom_data_i;
  assign wait_cycles         = word.payload[wait_ctr_width_p-1:0];
  assign unused_payload_bits = ^word.payload;

  bsg_test_rom_seq_wait_ctr #(
    .width_p(wait_ctr_width_p)
  ) wait_ctr (
    .clk       (clk_i),
    .reset     (reset_i),
    .load      (load),
    .load_value(wait_cycles - wait_ctr_width_p'(1)),
    .zero      (ctr_zero)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= eIdle;
      pc      <= '0;
      pending <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pending <= pending_n;
      error   <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pending_n = pending;
    error_n   = error;
    advance   = 1'b0;
    load      = 1'b0;
    send_v    = 1'b0;

    unique case (state)
      eIdle: begin
        if (en_i) state_n = eRun;
      end
      eRun: begin
        // pending keeps an offered SEND alive across an en_i drop
        if (en_i || pending) begin
          case (word.opcode)
            e_nop:  advance = 1'b1;
            e_send: begin
              send_v    = 1'b1;
              advance   = ready_i;
              pending_n = ~ready_i;
            end
            e_wait: begin
              advance = 1'b1;
              if (wait_cycles != '0) begin
                load    = 1'b1;
                state_n = eWait;
              end
            end
            e_finish: state_n = eDone;
            e_goto:   pc_n = word.payload[rom_addr_width_p-1:0];
            default: begin
              error_n = 1'b1;
              advance = 1'b1;
            end
          endcase
        end
      end
      eWait: begin
        if (ctr_zero) state_n = eRun;
      end
      eDone: begin
      end
      default: state_n = eIdle;
    endcase

    if (advance) begin
      pc_n = pc + rom_addr_width_p'(1);
      if (pc == {rom_addr_width_p{1'b1}}) error_n = 1'b1;
    end
  end

  assign rom_addr_o = pc;
  assign v_o        = send_v;
  assign data_o     = word.payload;
  assign done_o     = (state == eDone);
  assign error_o    = error;

`ifdef BSG_NONSYNTH_TEST_ROM_SEQUENCER_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state == eRun && (en_i || pending) && !(send_v && !ready_i))
        $display("[%0t] pc=%0d op=%s payload=0x%0h", $time, pc,
                 opcode_e'(word.opcode).name(), word.payload);
      if (send_v && ready_i)
        $display("[%0t] send accepted data=0x%0h", $time, word.payload);
      if (error_n && !error)
        $error("[%0t] sequencer error at pc=%0d opcode=0x%0h", $time, pc, word.opcode);
    end
  end
`else
  // trace output compiled out
`endif

endmodule
